// File: rtl/serial_add_sub_if.sv
// Handshake/operand bundle for the digit-serial adder/subtractor.
//   master: drives start, mode, a, b, cin; observes busy, done, result, cout, ovf
//   slave : the datapath side (serial_add_sub)
interface serial_add_sub_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, mode, a, b, cin,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, mode, a, b, cin,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: a+b+cin or a-b-cin, DIGIT bits per clock, LSB digit first.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.start  : request (sampled in IDLE only); bus.mode 0=add, 1=subtract
//   bus.a/b/cin: operands and carry/borrow-in, latched on the accepting edge
//   bus.busy   : high while not IDLE; bus.done: one-cycle completion pulse
//   bus.result/cout/ovf: sum/difference, carry (add) or borrow (sub), signed overflow
// WIDTH must be >= 2 and a multiple of DIGIT.
module serial_add_sub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_add_sub_if.slave   bus
);
  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned SUM_W = DIGIT + 1;
  localparam int unsigned MSB   = WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
  logic             mode_q, mode_d, carry_q, carry_d;
  logic             busy_q, busy_d, done_q, done_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [IDX_W-1:0] base;
  logic [DIGIT-1:0] a_dig, b_dig;
  logic [SUM_W-1:0] dig_sum;
  logic [WIDTH-1:0] acc_full;

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    mode_d   = mode_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    // Current digit; subtraction adds the inverted b digit
    base    = IDX_W'(32'(step_q) * DIGIT);
    a_dig   = a_q[base +: DIGIT];
    b_dig   = mode_q ? ~b_q[base +: DIGIT] : b_q[base +: DIGIT];
    dig_sum = SUM_W'(a_dig) + SUM_W'(b_dig) + SUM_W'(carry_q);

    acc_full = acc_q;
    acc_full[base +: DIGIT] = dig_sum[DIGIT-1:0];

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          mode_d  = bus.mode;
          // a - b - cin is computed as a + ~b + ~cin
          carry_d = bus.mode ? ~bus.cin : bus.cin;
          acc_d   = '0;
          step_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = acc_full;
        carry_d = dig_sum[DIGIT];
        step_d  = step_q + CNT_W'(1);
        if (step_q == CNT_W'(STEPS - 1)) begin
          state_d  = S_DONE;
          result_d = acc_full;
          cout_d   = mode_q ? ~dig_sum[DIGIT] : dig_sum[DIGIT];
          ovf_d    = (mode_q ? (a_q[MSB] != b_q[MSB]) : (a_q[MSB] == b_q[MSB]))
                     && (acc_full[MSB] != a_q[MSB]);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      mode_q   <= mode_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
endmodule
